// File: rtl/envelope_adsr.sv
// ADSR envelope generator that scales a valid/ready sample stream by the
// current envelope level. Level moves only on accepted samples; state moves
// on any clock edge.
// Optional feature: define ENVELOPE_ROUNDING_EN to round the scaled result
// half up instead of truncating toward negative infinity.
module envelope_adsr #(
  parameter int unsigned width_p        = 12,
  parameter int unsigned env_width_p    = 8,
  parameter int unsigned attack_rate_p  = 1,
  parameter int unsigned decay_rate_p   = 1,
  parameter int unsigned release_rate_p = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   gate_i,
  input  logic [env_width_p-1:0] sustain_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [width_p-1:0]     data_o,
  output logic                   active_o
);

  localparam int unsigned prod_w = width_p + env_width_p + 1;

  localparam logic [env_width_p-1:0] lmax_c = '1;
  localparam logic [env_width_p-1:0] atk_c  = env_width_p'(attack_rate_p);
  localparam logic [env_width_p-1:0] dcy_c  = env_width_p'(decay_rate_p);
  localparam logic [env_width_p-1:0] rel_c  = env_width_p'(release_rate_p);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTACK,
    S_DECAY,
    S_SUSTAIN,
    S_RELEASE
  } state_e;

  state_e                 state_q, state_n;
  logic [env_width_p-1:0] level_q, level_n;

  logic                   accept_c;
  logic [env_width_p:0]   atk_sum;
  logic [env_width_p-1:0] atk_sat;
  logic [env_width_p-1:0] dcy_sub;
  logic [env_width_p-1:0] dcy_sat;
  logic [env_width_p-1:0] rel_sat;

  logic [prod_w-1:0]        data_ext;
  logic [prod_w-1:0]        lvl_ext;
  logic signed [prod_w-1:0] prod;
  logic signed [prod_w-1:0] prod_r;
  logic [width_p-1:0]       scaled;
  logic                     unused_prod_bits;

  assign ready_o  = ~valid_o | ready_i;
  assign accept_c = valid_i & ready_o;

  // Saturating level steps; each rate never exceeds LMAX so one carry bit suffices
  always_comb begin
    atk_sum = {1'b0, level_q} + {1'b0, atk_c};
    atk_sat = atk_sum[env_width_p] ? lmax_c : atk_sum[env_width_p-1:0];
    dcy_sub = (level_q > dcy_c) ? (level_q - dcy_c) : '0;
    dcy_sat = (dcy_sub > sustain_i) ? dcy_sub : sustain_i;
    rel_sat = (level_q > rel_c) ? (level_q - rel_c) : '0;
  end

  // Signed sample times unsigned level; the full-width product cannot overflow
  always_comb begin
    data_ext = {{(env_width_p + 1){data_i[width_p-1]}}, data_i};
    lvl_ext  = {{width_p{1'b0}}, 1'b0, level_q};
    prod     = $signed(data_ext) * $signed(lvl_ext);
`ifdef ENVELOPE_ROUNDING_EN
    prod_r   = prod + $signed(prod_w'(1) << (env_width_p - 1));
`else
    prod_r   = prod;
`endif
    scaled   = prod_r[env_width_p +: width_p];
  end

  // Bits below the binary point and the spare sign bit are dropped by design
  assign unused_prod_bits = ^{prod_r[prod_w-1], prod_r[env_width_p-1:0]};

  // Next-state and next-level decode
  always_comb begin
    state_n = state_q;
    level_n = level_q;
    unique case (state_q)
      S_IDLE: begin
        level_n = '0;
        if (gate_i) state_n = S_ATTACK;
      end
      S_ATTACK: begin
        if (!gate_i) begin
          state_n = S_RELEASE;
        end else if (level_q == lmax_c) begin
          state_n = S_DECAY;
        end else if (accept_c) begin
          level_n = atk_sat;
          if (atk_sat == lmax_c) state_n = S_DECAY;
        end
      end
      S_DECAY: begin
        if (!gate_i) begin
          state_n = S_RELEASE;
        end else if (level_q <= sustain_i) begin
          level_n = sustain_i;
          state_n = S_SUSTAIN;
        end else if (accept_c) begin
          level_n = dcy_sat;
          if (dcy_sat <= sustain_i) state_n = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!gate_i) begin
          state_n = S_RELEASE;
        end else begin
          level_n = sustain_i;
        end
      end
      S_RELEASE: begin
        if (gate_i) begin
          state_n = S_ATTACK;
        end else if (level_q == '0) begin
          state_n = S_IDLE;
        end else if (accept_c) begin
          level_n = rel_sat;
          if (rel_sat == '0) state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        level_n = '0;
      end
    endcase
  end

  // State, level and activity flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      level_q  <= '0;
      active_o <= 1'b0;
    end else begin
      state_q  <= state_n;
      level_q  <= level_n;
      active_o <= (state_n != S_IDLE);
    end
  end

  // Output skid register: load on accept, drop on consume, hold on stall
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (accept_c) begin
      valid_o <= 1'b1;
      data_o  <= scaled;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_envelope_adsr.sv
// Self-checking bench for envelope_adsr: a cycle reference model pushes the
// expected scaled sample on every accept, and the monitor pops and compares
// on every output transfer.
module tb_envelope_adsr;

  localparam int W    = 12;
  localparam int E    = 8;
  localparam int ATK  = 64;
  localparam int DCY  = 16;
  localparam int REL  = 32;
  localparam int LMAX = 255;
`ifdef ENVELOPE_ROUNDING_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic         clk_i;
  logic         reset_i;
  logic         gate_i;
  logic [E-1:0] sustain_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         active_o;

  envelope_adsr #(
    .width_p       (W),
    .env_width_p   (E),
    .attack_rate_p (ATK),
    .decay_rate_p  (DCY),
    .release_rate_p(REL)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .gate_i   (gate_i),
    .sustain_i(sustain_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .active_o (active_o)
  );

  int n_total = 0;
  int n_bad   = 0;

  int exp_q[$];
  int log_q[$];
  bit log_en = 1'b0;

  int m_state = M_IDLE;
  int m_level = 0;
  int m_valid = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int scale(input int d, input int lv);
    return (d * lv + RND) >>> E;
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle with inputs settled
  always @(negedge clk_i) begin
    int  d;
    bit  acc;
    bit  exp_ready;
    int  sus;
    exp_ready = (m_valid == 0) || ready_i;
    chk("ready_o", int'(ready_o), int'(exp_ready));
    chk("valid_o", int'(valid_o), m_valid);
    chk("active_o", int'(active_o), int'(m_state != M_IDLE));
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("data_o", int'($signed(data_o)), e);
        if (log_en) log_q.push_back(int'($signed(data_o)));
      end
    end
    if (reset_i) begin
      exp_q.delete();
      m_state = M_IDLE;
      m_level = 0;
      m_valid = 0;
    end else begin
      acc = valid_i && exp_ready;
      d   = int'($signed(data_i));
      sus = int'(sustain_i);
      if (acc) exp_q.push_back(scale(d, m_level));
      if (acc) m_valid = 1;
      else if (ready_i) m_valid = 0;
      case (m_state)
        M_IDLE: begin
          m_level = 0;
          if (gate_i) m_state = M_ATK;
        end
        M_ATK: begin
          if (!gate_i) m_state = M_REL;
          else if (m_level == LMAX) m_state = M_DEC;
          else if (acc) begin
            m_level = (m_level + ATK > LMAX) ? LMAX : m_level + ATK;
            if (m_level == LMAX) m_state = M_DEC;
          end
        end
        M_DEC: begin
          if (!gate_i) m_state = M_REL;
          else if (m_level <= sus) begin
            m_level = sus;
            m_state = M_SUS;
          end else if (acc) begin
            m_level = (m_level - DCY < sus) ? sus : m_level - DCY;
            if (m_level == sus) m_state = M_SUS;
          end
        end
        M_SUS: begin
          if (!gate_i) m_state = M_REL;
          else m_level = sus;
        end
        default: begin
          if (gate_i) m_state = M_ATK;
          else if (m_level == 0) m_state = M_IDLE;
          else if (acc) begin
            m_level = (m_level - REL < 0) ? 0 : m_level - REL;
            if (m_level == 0) m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int lv[14];
    int held;
    lv = '{0, 0, 64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128};

    reset_i   = 1'b1;
    gate_i    = 1'b0;
    sustain_i = 8'd128;
    valid_i   = 1'b0;
    data_i    = '0;
    ready_i   = 1'b1;
    cyc(2);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_active", int'(active_o), 0);
    reset_i = 1'b0;
    chk("rst_ready", int'(ready_o), 1);

    // Gate low: samples pass through at level zero
    valid_i = 1'b1;
    data_i  = 12'sd2047;
    cyc(4);
    chk("idle_active", int'(active_o), 0);
    valid_i = 1'b0;
    cyc(2);

    // Full attack and decay into sustain with a logged output sequence
    log_en  = 1'b1;
    gate_i  = 1'b1;
    valid_i = 1'b1;
    cyc(20);
    log_en = 1'b0;
    chk("seq_len_ok", int'(log_q.size() >= 14), 1);
    if (log_q.size() >= 14)
      for (int i = 0; i < 14; i++) chk($sformatf("seq%0d", i), log_q[i], scale(2047, lv[i]));

    // Downstream stall in sustain holds the output register
    ready_i = 1'b0;
    held    = int'($signed(data_o));
    chk("stall_pre_held", held, scale(2047, 128));
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_data", int'($signed(data_o)), held);
      chk("stall_valid", int'(valid_o), 1);
      chk("stall_ready", int'(ready_o), 0);
    end
    ready_i = 1'b1;
    cyc(3);

    // Most negative sample at level 128
    data_i = 12'h800;
    cyc(2);
    chk("neg_full", int'($signed(data_o)), scale(-2048, 128));
    data_i = 12'sd2047;

    // Release, retrigger from the current level, release to idle
    gate_i = 1'b0;
    cyc(3);
    gate_i = 1'b1;
    cyc(2);
    gate_i = 1'b0;
    cyc(10);
    chk("rel_idle_active", int'(active_o), 0);

    // Reset in the middle of attack drops everything
    gate_i = 1'b1;
    cyc(3);
    reset_i = 1'b1;
    cyc(1);
    chk("mid_rst_data", int'(data_o), 0);
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_active", int'(active_o), 0);
    reset_i = 1'b0;
    chk("mid_rst_ready", int'(ready_o), 1);
    cyc(1);

    // Sustain at LMAX, then sustain tracking, then release
    gate_i    = 1'b0;
    valid_i   = 1'b0;
    cyc(2);
    sustain_i = 8'd255;
    gate_i    = 1'b1;
    valid_i   = 1'b1;
    cyc(8);
    sustain_i = 8'd200;
    cyc(3);
    chk("track_sus", int'($signed(data_o)), scale(2047, 200));
    gate_i = 1'b0;
    cyc(12);
    valid_i = 1'b0;
    cyc(3);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/envelope_adsr.md
ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 SHALL have parameter width_p, default 12: signed two's-complement sample width on data_i and data_o.
REQ-002 SHALL have parameter env_width_p, default 8: unsigned envelope level width; LMAX = 2^env_width_p - 1.
REQ-003 SHALL have parameters attack_rate_p, decay_rate_p and release_rate_p, each default 1: level step per accepted sample; each legal range is 1..LMAX.
REQ-004 SHALL have one clock and synchronous active-high reset: clk_i  in  1  clock; reset_i  in  1  synchronous active-high reset.
REQ-005 SHALL have port: gate_i  in  1  note on (1) / note off (0), sampled every cycle.
REQ-006 SHALL have port: sustain_i  in  env_width_p  sustain level, sampled every cycle.
REQ-007 SHALL have upstream ports: valid_i  in  1; ready_o  out  1; data_i  in  width_p  signed sample.
REQ-008 SHALL have downstream ports: valid_o  out  1; ready_i  in  1; data_o  out  width_p  signed scaled sample.
REQ-009 SHALL have port: active_o  out  1  high whenever the state is not IDLE.

Function
REQ-010 SHALL define accept = valid_i & ready_o, and SHALL drive ready_o = ~valid_o | ready_i.
REQ-011 SHALL register the scaled sample into data_o and set valid_o on the edge after accept (one-cycle latency); valid_o SHALL clear when ready_i=1 and no new accept occurs.
REQ-012 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-013 SHALL compute data_o = (data_i * {1'b0,level}) >>> env_width_p, where the product is signed, full-width (width_p+env_width_p+1 bits) and then truncated to width_p bits; this cannot overflow.
REQ-014 SHALL scale each accepted sample by the registered level in effect before that cycle's level update.
REQ-015 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE; state changes occur on any clock edge, while level changes only on accept.
REQ-016 IDLE: level=0 and samples still pass (output 0); when gate_i=1, SHALL go to ATTACK.
REQ-017 ATTACK: on accept, level = min(level+attack_rate_p, LMAX); on reaching LMAX, SHALL go to DECAY.
REQ-018 DECAY: on accept, level = max(level-decay_rate_p, sustain_i); when level <= sustain_i, SHALL set level=sustain_i and go to SUSTAIN.
REQ-019 SUSTAIN: level SHALL track sustain_i each cycle.
REQ-020 When gate_i=0 in ATTACK, DECAY or SUSTAIN, SHALL go to RELEASE immediately, keeping the current level.
REQ-021 RELEASE: on accept, level = max(level-release_rate_p, 0); at level 0, SHALL go to IDLE.
REQ-022 When gate_i=1 in RELEASE, SHALL go to ATTACK from the current level (retrigger, no reset to 0).
REQ-023 All level arithmetic SHALL saturate and never wrap.
REQ-024 When sustain_i=LMAX, DECAY SHALL go to SUSTAIN on its first cycle.

Reset
REQ-025 On reset_i=1 at a clock edge, SHALL set: state=IDLE, level=0, valid_o=0, data_o=0, active_o=0.
REQ-026 Reset mid-note or mid-stall SHALL drop the held output sample; ready_o SHALL be 1 on the cycle after reset.

Configuration
REQ-027 With macro ENVELOPE_ROUNDING_EN defined, SHALL add 2^(env_width_p-1) to the product before the shift (round half up).
REQ-028 Without ENVELOPE_ROUNDING_EN, SHALL truncate toward negative infinity (arithmetic shift only).

Verification (width_p=12, env_width_p=8, attack=64, decay=16, release=32, sustain_i=128, ready_i=1 unless stated)
REQ-029 Reset held 2 cycles -> valid_o=0, data_o=0, active_o=0, ready_o=1 after release.
REQ-030 gate_i=0, data_i=2047 streamed -> data_o=0 every sample, active_o=0.
REQ-031 gate_i=1, data_i=2047 streamed -> levels 0,64,128,192,255 then 239..128 in steps of 16, then SUSTAIN; outputs 0,511,1023,1535,2039,...,1023 (512 at level 64 with ENVELOPE_ROUNDING_EN).
REQ-032 In SUSTAIN, ready_i=0 for 5 cycles -> data_o/valid_o stable, ready_o=0, level stays 128.
REQ-033 gate_i=0 in SUSTAIN -> levels 96,64; gate_i=1 -> ATTACK at 128; gate_i=0 again -> release to 0, then IDLE, active_o=0.
REQ-034 data_i=-2048 at level 128 -> data_o=-1024; reset asserted mid-ATTACK -> IDLE, data_o=0 next cycle.
